synaptic_current_gen: RTL
=========================

// Module: synaptic_current_gen
// PURPOSE
//  Spike-to-current synapse: converts presynaptic spikes (a level output of an upstream neuron) into a signed
//  synaptic current word that feeds a downstream neuron's current input. It is the inverse of the neuron:
//  neuron = current in, spike out; this block = spike in, current out. Exponentially decaying current,
//  updated once per integration tick.
// PARAMETERS
//  WIDTH          16       current / weight word width, two's complement
//  DECAY_SHIFT    3        per-tick decay: acc -= acc >>> DECAY_SHIFT
//  PEND_BITS      3        width of pending-spike counter (max 2^PEND_BITS-1 spikes per tick)
//  REFRACT_TICKS  0        ticks after an accepted spike during which new edges are dropped; 0 = disabled
//  W_INIT         16'sd100 weight loaded at reset
// PORTS
//  clock          in   1      clock
//  reset          in   1      reset, synchronous, active-high
//  tick           in   1      integration strobe (one dt step), single-cycle pulse
//  spike_in       in   1      presynaptic spike level, synchronous to clock
//  weight_valid   in   1      weight write request
//  weight_data    in   WIDTH  signed weight
//  weight_ready   out  1      weight write accepted when valid&ready
//  current_out    out  WIDTH  signed synaptic current, registered
//  current_valid  out  1      one-cycle pulse: current_out just updated
//  overrun        out  1      sticky: tick arrived while busy
// BEHAVIOUR
//  Reset: current_out=0, acc=0, weight=W_INIT, pending=0, refract=0, current_valid=0, overrun=0, FSM=IDLE,
//   spike_in history=0. Reset mid-operation aborts any update; all values above apply on the next cycle.
//  Edge detect: event = spike_in & ~spike_d (spike_d = registered spike_in). Event accepted iff refract==0;
//   an accepted event increments pending, saturating at 2^PEND_BITS-1. If REFRACT_TICKS>0 it loads
//   refract=REFRACT_TICKS. Dropped events have no effect.
//  FSM IDLE -> DECAY -> ADD(k cycles) -> DONE -> IDLE.
//   IDLE: on tick, snapshot k = pending + (accepted event this cycle), clear pending, go to DECAY.
//         Events accepted during DECAY/ADD/DONE accumulate in pending for the next tick.
//   DECAY: acc <= acc - (acc >>> DECAY_SHIFT), arithmetic shift (floor). If refract!=0, refract decrements,
//          except when it was loaded by the event captured in the snapshot.
//   ADD:   acc <= sat(acc + weight) once per cycle, k cycles; k==0 skips straight to DONE.
//   DONE:  current_out <= acc; current_valid=1 for this cycle only.
//   Latency: tick in cycle T -> current_valid in cycle T+2+k; current_out holds the new value from T+2+k on.
//  Saturation: every add is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; decay cannot overflow.
//  Tick outside IDLE: ignored (not queued), overrun<=1 until reset.
//  Weight handshake: weight_ready = (state==IDLE) & ~tick. On valid&ready, weight<=weight_data the next cycle.
//   A new weight applies to the next tick. weight_valid may stay high; the request is held until accepted.
//  Simultaneous event+tick in IDLE: event included in that tick's snapshot.
// STRUCTURE
//  Shared package: FSM state enum (IDLE, DECAY, ADD, DONE), sat_add function, WIDTH default constant.
//  One sub-module: syn_edge_refract (edge detect + refractory counter + pending counter).
//  The FSM/accumulator stays in the top module.
// TESTING
//  1 Reset, no stimulus -> current_out=0, weight_ready=1, current_valid=0, overrun=0.
//  2 One spike edge, then tick at T -> current_valid at T+3, current_out=100.
//    Next two ticks with no spikes -> 88 (100-12), then 77 (88-11); each valid at tick+2.
//  3 weight=0x7000, 2 edges, tick -> 0x7FFF.
//    weight=-0x7000 from acc=0, 2 edges, tick -> 0x8000; next empty tick -> 0x9000 (-28672).
//  4 9 edges in one window (PEND_BITS=3) -> k=7, current_out=700, valid at T+9.
//    Second tick at T+4 -> overrun=1, ignored; result unchanged; reset clears overrun.
//  5 REFRACT_TICKS=2: edge, tick, edge, tick, edge, tick -> second edge dropped, third accepted:
//    outputs 100, 88, 177.
//  6 weight_valid with tick in same cycle -> weight_ready=0, weight written only after DONE.
//    Reset asserted during ADD -> next cycle all outputs at reset values, weight=W_INIT.

Source files
------------

// File: rtl/synaptic_current_gen_pkg.sv
// Shared types and helpers for the spike-to-current synapse.
package synaptic_current_gen_pkg;

  localparam int WIDTH_DEF = 16;

  // Update sequence run once per accepted integration tick.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DECAY = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed add clamped to the range of a w-bit two's complement word (w <= 31).
  // The result is returned sign-extended to 32 bits; callers keep the low w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi) begin
      sat_add = hi[31:0];
    end else if (sum < lo) begin
      sat_add = lo[31:0];
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/syn_edge_refract.sv
// Presynaptic front end: rising-edge detect on the spike level, refractory
// window that drops edges, and a saturating count of spikes waiting for the
// next integration tick.
module syn_edge_refract #(
  parameter int PEND_BITS     = 3,
  parameter int REFRACT_TICKS = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spike_in,
  input  logic                 snapshot,    // tick taken in IDLE this cycle
  input  logic                 decay_step,  // update sequence is in DECAY
  output logic [PEND_BITS-1:0] snap_k       // spikes to apply for this tick
);

  localparam int RW = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;
  localparam logic [PEND_BITS-1:0] P_MAX = '1;

  logic                 spike_d;
  logic [PEND_BITS-1:0] pending_q;
  logic [RW-1:0]        refract_q;
  logic                 skip_dec_q;
  logic                 ev_acc;

  // An edge only counts while no refractory window is running.
  assign ev_acc = spike_in & ~spike_d & (refract_q == '0);

  // Snapshot includes an edge landing in the same cycle as the tick.
  always_comb begin
    snap_k = pending_q;
    if (ev_acc && (pending_q != P_MAX)) begin
      snap_k = pending_q + 1'b1;
    end
  end

  // Edge history, pending count and refractory countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      spike_d    <= 1'b0;
      pending_q  <= '0;
      refract_q  <= '0;
      skip_dec_q <= 1'b0;
    end else begin
      spike_d <= spike_in;
      if (snapshot) begin
        pending_q <= '0;
      end else if (ev_acc && (pending_q != P_MAX)) begin
        pending_q <= pending_q + 1'b1;
      end
      // A window opened by the snapshot's own edge is not shortened by the
      // decay step that immediately follows it.
      skip_dec_q <= snapshot & ev_acc;
      if (ev_acc && (REFRACT_TICKS > 0)) begin
        refract_q <= RW'(REFRACT_TICKS);
      end else if (decay_step && (refract_q != '0) && !skip_dec_q) begin
        refract_q <= refract_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/synaptic_current_gen.sv
// Spike-to-current synapse: exponentially decaying accumulator bumped by the
// synaptic weight once per presynaptic spike, updated on each integration tick.
//
// Weight handshake: a write transfers on a clock edge where weight_valid and
// weight_ready are both high; weight_ready is high only while idle and no tick
// is present, and the requester holds weight_valid/weight_data until transfer.
module synaptic_current_gen
  import synaptic_current_gen_pkg::*;
#(
  parameter int                      WIDTH         = WIDTH_DEF,
  parameter int                      DECAY_SHIFT   = 3,
  parameter int                      PEND_BITS     = 3,
  parameter int                      REFRACT_TICKS = 0,
  parameter logic signed [WIDTH-1:0] W_INIT        = WIDTH'(100)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    spike_in,
  input  logic                    weight_valid,
  input  logic signed [WIDTH-1:0] weight_data,
  output logic                    weight_ready,
  output logic signed [WIDTH-1:0] current_out,
  output logic                    current_valid,
  output logic                    overrun,
  output state_t                  dbg_state
);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] weight_q;
  logic signed [WIDTH-1:0] out_q;
  logic                    valid_q;
  logic                    overrun_q;
  logic [PEND_BITS-1:0]    k_q;
  logic [PEND_BITS-1:0]    snap_k;
  logic signed [31:0]      sum_sat;
  logic                    snapshot;

  assign snapshot      = (state_q == IDLE) && tick;
  assign weight_ready  = (state_q == IDLE) && !tick;
  assign current_out   = out_q;
  assign current_valid = valid_q;
  assign overrun       = overrun_q;
  assign dbg_state     = state_q;
  assign sum_sat       = sat_add(32'(acc_q), 32'(weight_q), WIDTH);

  syn_edge_refract #(
    .PEND_BITS    (PEND_BITS),
    .REFRACT_TICKS(REFRACT_TICKS)
  ) u_edge (
    .clock     (clock),
    .reset     (reset),
    .spike_in  (spike_in),
    .snapshot  (snapshot),
    .decay_step(state_q == DECAY),
    .snap_k    (snap_k)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and next accumulator value for the decay/add sequence.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (tick) state_d = DECAY;
      end
      DECAY: begin
        acc_d   = acc_q - (acc_q >>> DECAY_SHIFT);
        state_d = (k_q == '0) ? DONE : ADD;
      end
      ADD: begin
        acc_d = sum_sat[WIDTH-1:0];
        if (k_q == PEND_BITS'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: accumulator, add count, published current, flags and weight.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= '0;
      k_q       <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      weight_q  <= W_INIT;
    end else begin
      acc_q <= acc_d;
      if (snapshot) begin
        k_q <= snap_k;
      end else if (state_q == ADD) begin
        k_q <= k_q - 1'b1;
      end
      // Publish the final value as DONE is entered so it is visible while
      // current_valid is high.
      if (state_d == DONE) out_q <= acc_d;
      valid_q <= (state_d == DONE);
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      if (weight_valid && weight_ready) weight_q <= weight_data;
    end
  end

endmodule
